// File: rtl/emergency_preempt.sv
// Emergency vehicle preemption controller.
// On a request, the controller runs one approach through all-red clearance, an
// emergency green and a yellow, then returns to idle or serves the next request.
// Optional build macro: EMER_LATCH_EN. When it is defined, request pulses are held
// in sticky pending bits. When it is undefined, pending follows the live emer_req.
module emergency_preempt #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned CLR_TIME  = 1,
    parameter int unsigned HOLD_TIME = 30,
    parameter int unsigned YEL_TIME  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [NUM_CH-1:0]         emer_req,
    output logic [NUM_CH-1:0]         red,
    output logic [NUM_CH-1:0]         yel,
    output logic [NUM_CH-1:0]         grn,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] active_ch
);

    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_TIME - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TIME - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YEL_TIME - 1);

    // Sparse encoding so that corrupted state values exist and fall to idle.
    typedef enum logic [2:0] {
        StIdle   = 3'b000,
        StClear  = 3'b001,
        StGreen  = 3'b010,
        StYellow = 3'b100
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CH_W-1:0]   r_active;
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_pend_other;
    logic              w_load;
    logic [CH_W-1:0]   w_load_ch;

    // Lowest-index set bit; fixed priority.
    function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] v);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (v[i]) r = CH_W'(i);
        end
        return r;
    endfunction

`ifdef EMER_LATCH_EN
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] w_load_mask;

    assign w_load_mask = w_load ? (NUM_CH'(1) << w_load_ch) : '0;
    assign w_pend      = r_pend | emer_req;

    // Sticky pending bits, cleared only when the channel is taken into service.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pend <= '0;
        else       r_pend <= w_pend & ~w_load_mask;
    end
`else
    assign w_pend = emer_req;
`endif

    // The channel in service is not a candidate for the follow-on at yellow exit.
    assign w_pend_other = w_pend & ~(NUM_CH'(1) << r_active);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    // Next-state and channel-load decision.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_ch    = lowest(w_pend);
        case (r_state)
            StIdle: begin
                if (|w_pend) begin
                    w_state_next = StClear;
                    w_load       = 1'b1;
                end
            end
            StClear: begin
                if (tick && r_cnt == CLR_LAST) w_state_next = StGreen;
            end
            StGreen: begin
                if (tick && r_cnt == HOLD_LAST) w_state_next = StYellow;
            end
            StYellow: begin
                if (tick && r_cnt == YEL_LAST) begin
                    if (|w_pend_other) begin
                        w_state_next = StClear;
                        w_load       = 1'b1;
                        w_load_ch    = lowest(w_pend_other);
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Dwell counter: zero on every state entry and while idle, advances on tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state || r_state == StIdle) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Channel in service, loaded only when a new sequence starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_active <= '0;
        else if (w_load) r_active <= w_load_ch;
    end

    // Lamp decode straight from registered state; everything else stays red.
    always_comb begin
        red = '1;
        yel = '0;
        grn = '0;
        case (r_state)
            StGreen: begin
                red[r_active] = 1'b0;
                grn[r_active] = 1'b1;
            end
            StYellow: begin
                red[r_active] = 1'b0;
                yel[r_active] = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (r_state != StIdle);
    assign active_ch = r_active;

endmodule

// File: tb/tb_emergency_preempt.sv
// Self-checking bench for emergency_preempt: per-cycle lamp snapshots are queued
// when a request is driven and popped one per clock as the DUT steps.
module tb_emergency_preempt;

    typedef struct packed {
        logic       busy;
        logic [1:0] ch;
        logic [3:0] red;
        logic [3:0] yel;
        logic [3:0] grn;
    } snap_t;

    logic       clk;
    logic       reset;
    logic       tick1, tick2;
    logic [3:0] req1, req2;
    logic [3:0] red1, yel1, grn1, red2, yel2, grn2;
    logic       busy1, busy2;
    logic [1:0] ch1, ch2;

    int errors = 0;
    int checks = 0;
    snap_t sb[$];

    emergency_preempt dut1 (
        .clk(clk), .reset(reset), .tick(tick1), .emer_req(req1),
        .red(red1), .yel(yel1), .grn(grn1), .busy(busy1), .active_ch(ch1)
    );

    emergency_preempt #(.HOLD_TIME(3)) dut2 (
        .clk(clk), .reset(reset), .tick(tick2), .emer_req(req2),
        .red(red2), .yel(yel2), .grn(grn2), .busy(busy2), .active_ch(ch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // st: 0 idle, 1 clear, 2 green, 3 yellow
    function automatic snap_t mk(input int st, input int ch);
        snap_t s;
        s.busy = (st != 0);
        s.ch   = 2'(ch);
        s.red  = 4'hF;
        s.yel  = 4'h0;
        s.grn  = 4'h0;
        if (st == 2) begin s.red[ch] = 1'b0; s.grn[ch] = 1'b1; end
        if (st == 3) begin s.red[ch] = 1'b0; s.yel[ch] = 1'b1; end
        return s;
    endfunction

    task automatic push_n(input int st, input int ch, input int n);
        for (int i = 0; i < n; i++) sb.push_back(mk(st, ch));
    endtask

    task automatic push_service(input int ch, input int c, input int g, input int y);
        push_n(1, ch, c);
        push_n(2, ch, g);
        push_n(3, ch, y);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        checks++;
        if (red1 !== 4'hF) begin errors++; $display("FAIL reset_red got=%h exp=f", red1); end
        checks++;
        if (yel1 !== 4'h0 || grn1 !== 4'h0) begin
            errors++; $display("FAIL reset_yel_grn got=%h/%h exp=0/0", yel1, grn1);
        end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy1); end
        checks++;
        if (ch1 !== 2'd0) begin errors++; $display("FAIL reset_ch got=%0d exp=0", ch1); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        snap_t e, o;
        int k;
        req1 = 4'b0100;
        push_service(2, 1, 30, 2);
        push_n(0, 0, 2);
        k = 0;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            o = {busy1, ch1, red1, yel1, grn1};
            e = sb.pop_front();
            checks++;
            if (o.busy !== e.busy || o.red !== e.red || o.yel !== e.yel || o.grn !== e.grn ||
                (e.busy && o.ch !== e.ch)) begin
                errors++; $display("FAIL single k=%0d got=%h exp=%h", k, o, e);
            end
            if (k == 0) req1 = 4'b0000;
            k++;
        end
    endtask

    task automatic test_back_to_back;
        snap_t e, o;
        int k;
        req1 = 4'b1010;
        push_service(1, 1, 30, 2);
        push_service(3, 1, 30, 2);
        push_n(0, 0, 2);
        k = 0;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            o = {busy1, ch1, red1, yel1, grn1};
            e = sb.pop_front();
            checks++;
            if (o.busy !== e.busy || o.red !== e.red || o.yel !== e.yel || o.grn !== e.grn ||
                (e.busy && o.ch !== e.ch)) begin
                errors++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, o, e);
            end
            if (k == 0)  req1 = 4'b1000;
            if (k == 33) req1 = 4'b0000;
            k++;
        end
    endtask

    task automatic test_pulse;
        snap_t e, o;
        int k;
        req1 = 4'b0100;
        push_service(2, 1, 30, 2);
`ifdef EMER_LATCH_EN
        push_service(0, 1, 30, 2);
`endif
        push_n(0, 0, 3);
        k = 0;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            o = {busy1, ch1, red1, yel1, grn1};
            e = sb.pop_front();
            checks++;
            if (o.busy !== e.busy || o.red !== e.red || o.yel !== e.yel || o.grn !== e.grn ||
                (e.busy && o.ch !== e.ch)) begin
                errors++; $display("FAIL pulse k=%0d got=%h exp=%h", k, o, e);
            end
            if (k == 0) req1 = 4'b0000;
            if (k == 5) req1 = 4'b0001;
            if (k == 6) req1 = 4'b0000;
            k++;
        end
    endtask

    task automatic test_reset_mid;
        snap_t e, o;
        int k;
        req1 = 4'b0100;
        push_n(1, 2, 1);
        push_n(2, 2, 10);
        k = 0;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            o = {busy1, ch1, red1, yel1, grn1};
            e = sb.pop_front();
            checks++;
            if (o.busy !== e.busy || o.red !== e.red || o.yel !== e.yel || o.grn !== e.grn ||
                (e.busy && o.ch !== e.ch)) begin
                errors++; $display("FAIL reset_mid_run k=%0d got=%h exp=%h", k, o, e);
            end
            if (k == 0) req1 = 4'b0000;
            k++;
        end
        // Mid-cycle assertion, well before the next rising edge.
        #1 reset = 1'b1;
        #1;
        checks++;
        if (red1 !== 4'hF) begin errors++; $display("FAIL async_red got=%h exp=f", red1); end
        checks++;
        if (grn1 !== 4'h0) begin errors++; $display("FAIL async_grn got=%h exp=0", grn1); end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL async_busy got=%b exp=0", busy1); end
        checks++;
        if (ch1 !== 2'd0) begin errors++; $display("FAIL async_ch got=%0d exp=0", ch1); end
        @(negedge clk);
        reset = 1'b0;
        push_n(0, 0, 6);
        k = 0;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            o = {busy1, ch1, red1, yel1, grn1};
            e = sb.pop_front();
            checks++;
            if (o.busy !== e.busy || o.red !== e.red || o.yel !== e.yel || o.grn !== e.grn) begin
                errors++; $display("FAIL no_resume k=%0d got=%h exp=%h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_tick_div;
        snap_t e, o;
        int k, cnt_m, grn_cyc;
        req2  = 4'b0100;
        tick2 = 1'b0;
        push_service(2, 3, 12, 8);
        push_n(0, 0, 2);
        k = 0;
        cnt_m = 0;
        grn_cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            o = {busy2, ch2, red2, yel2, grn2};
            e = sb.pop_front();
            checks++;
            if (o.busy !== e.busy || o.red !== e.red || o.yel !== e.yel || o.grn !== e.grn ||
                (e.busy && o.ch !== e.ch)) begin
                errors++; $display("FAIL tick_div k=%0d got=%h exp=%h", k, o, e);
            end
            if (grn2[2] === 1'b1) grn_cyc++;
            if (k >= 3 && k <= 14) begin
                if (k > 3 && (k % 4) == 3) cnt_m++;
                checks++;
                if (dut2.r_cnt !== 8'(cnt_m)) begin
                    errors++; $display("FAIL tick_cnt k=%0d got=%0d exp=%0d", k, dut2.r_cnt, cnt_m);
                end
            end
            if (k == 0) req2 = 4'b0000;
            tick2 = (((k + 1) % 4) == 3);
            k++;
        end
        tick2 = 1'b0;
        checks++;
        if (grn_cyc !== 12) begin
            errors++; $display("FAIL grn_dwell got=%0d exp=12", grn_cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tick1 = 1'b1;
        tick2 = 1'b0;
        req1  = 4'b0000;
        req2  = 4'b0000;
        test_reset();
        test_single();
        test_back_to_back();
        test_pulse();
        test_reset_mid();
        test_tick_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/emergency_preempt.md
EMERGENCY_PREEMPT -- requirements
Module: emergency_preempt

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of approach channels (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the internal tick counter.
REQ-003 The block SHALL have parameter CLR_TIME, default 1, meaning all-red clearance length in ticks (legal range 1..2^CNT_W-1).
REQ-004 The block SHALL have parameter HOLD_TIME, default 30, meaning emergency green length in ticks (legal range 1..2^CNT_W-1).
REQ-005 The block SHALL have parameter YEL_TIME, default 2, meaning yellow length in ticks (legal range 1..2^CNT_W-1).
REQ-006 The block SHALL have port clk, input, 1 bit, the clock.
REQ-007 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-008 The block SHALL have port tick, input, 1 bit, a one-cycle time-base pulse (nominally 1 s).
REQ-009 The block SHALL have port emer_req, input, NUM_CH bits, one emergency request per channel.
REQ-010 The block SHALL have ports red, yel and grn, each output, NUM_CH bits, the per-channel lamp drives.
REQ-011 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-012 The block SHALL have port active_ch, output, $clog2(NUM_CH) bits, the channel being served.

Function
REQ-013 The FSM SHALL have four states, IDLE, CLEAR, GREEN and YELLOW, held in a registered state encoding.
REQ-014 In IDLE, CLEAR and for non-active channels in every state, the block SHALL drive red=1, yel=0, grn=0.
REQ-015 The active channel SHALL be driven grn=1 only in GREEN and yel=1 only in YELLOW, with red=0 in both states.
REQ-016 Lamp outputs SHALL be a decode of the registered state and active_ch, changing on the same clock edge as the state, with no extra latency.
REQ-017 From IDLE, any pending request SHALL cause a transition to CLEAR on the next clock edge, independent of tick, and active_ch SHALL be loaded with the lowest-index pending channel.
REQ-018 The tick counter SHALL clear on every state entry and increment only on cycles where tick=1.
REQ-019 A timed state of length T SHALL exit on the edge where tick=1 and counter==T-1, giving exactly T ticks of dwell.
REQ-020 The state sequence SHALL be CLEAR -> GREEN (after CLR_TIME) -> YELLOW (after HOLD_TIME).
REQ-021 When YELLOW expires with another request pending, the FSM SHALL go directly to CLEAR, loading the new lowest-index channel; otherwise it SHALL return to IDLE.
REQ-022 A request on the channel currently being served SHALL neither restart nor extend its sequence.
REQ-023 Request changes during CLEAR, GREEN or YELLOW SHALL NOT alter active_ch.
REQ-024 Simultaneous requests SHALL be resolved by fixed priority, lowest index first.
REQ-025 An illegal state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-026 Asserting reset at any time, including mid-sequence, SHALL immediately force: state IDLE, counter 0, active_ch 0, busy 0, red all-ones, yel 0, grn 0, and pending latches cleared.
REQ-027 After reset deasserts, the first transition SHALL occur on the first clock edge that sees a pending request.

Configuration
REQ-028 With macro EMER_LATCH_EN defined, each emer_req bit SHALL set a sticky pending bit that is cleared only when that channel is loaded into active_ch, so a one-cycle pulse is served.
REQ-029 With EMER_LATCH_EN undefined, pending SHALL equal the live emer_req level, so a request deasserted before it is sampled in IDLE or at YELLOW exit is dropped.

Verification
REQ-030 The bench SHALL cover: defaults with tick every cycle, emer_req=4'b0100 held -> busy 1 next edge, active_ch=2, then 1 cycle all-red, grn[2] high 30 cycles, yel[2] high 2 cycles, then IDLE.
REQ-031 The bench SHALL cover: emer_req=4'b1010 in the same cycle -> channel 1 served first; channel 3 served directly after YELLOW with no IDLE cycle between.
REQ-032 The bench SHALL cover: tick every 4th cycle with HOLD_TIME=3 -> grn dwell of 12 cycles, and the counter does not advance on non-tick cycles.
REQ-033 The bench SHALL cover: reset pulsed at GREEN tick 10 -> outputs red=4'b1111, grn=0 and busy=0 immediately (asynchronously), with no resumption of the sequence.
REQ-034 The bench SHALL cover: a 1-cycle pulse on emer_req[0] during channel 2 GREEN -> served after channel 2 with EMER_LATCH_EN defined; never served with it undefined.
